// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: state encoding,
// word packing geometry and the LEN=0 => 256 words rule.
package imem_loader_pkg;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_LEN  = 3'd1;
   localparam logic [2:0] ST_DATA = 3'd2;
   localparam logic [2:0] ST_CHK  = 3'd3;
   localparam logic [2:0] ST_DONE = 3'd4;
   localparam logic [2:0] ST_ERR  = 3'd5;

   typedef enum logic [2:0] {
      S_IDLE = ST_IDLE,
      S_LEN  = ST_LEN,
      S_DATA = ST_DATA,
      S_CHK  = ST_CHK,
      S_DONE = ST_DONE,
      S_ERR  = ST_ERR
   } loader_state_t;

   localparam int LOADER_BYTES_PER_WORD = 4;

   // A LEN byte of zero requests a full 256-word image.
   localparam logic [8:0] LEN_ZERO_WORDS = 9'd256;

   function automatic logic [8:0] len_to_words(input logic [7:0] len);
      return (len == 8'd0) ? LEN_ZERO_WORDS : {1'b0, len};
   endfunction

endpackage

// File: rtl/imem_loader_byte_word_packer.sv
// Packs accepted stream bytes big-endian into 32-bit words and keeps the
// running XOR of every byte it has packed since the last clear.
module byte_word_packer
   import imem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        i_clear,
   input  logic        i_byte_en,
   input  logic [7:0]  i_byte,
   output logic [31:0] o_next_word,
   output logic [7:0]  o_xor,
   output logic        o_word_ready
);

   // Only the three earlier bytes of a word need storing; the fourth is the live input.
   logic [23:0] r_shift;
   logic [1:0]  r_idx;
   logic [7:0]  r_xor;

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values, regardless of statement order.
      if (rst || i_clear) begin
         r_shift <= '0;
         r_idx   <= '0;
         r_xor   <= '0;
      end else if (i_byte_en) begin
         r_shift <= {r_shift[15:0], i_byte};
         r_idx   <= r_idx + 2'd1;
         r_xor   <= r_xor ^ i_byte;
      end
   end

   assign o_next_word  = {r_shift, i_byte};
   assign o_xor        = r_xor;
   assign o_word_ready = i_byte_en && (r_idx == 2'(LOADER_BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives LEN / data / CHK byte frames, writes packed words to
// instruction memory from address 0 and holds the CPU until the checksum verifies.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_start,
   input  logic              i_in_valid,
   input  logic [7:0]        i_in_data,
   output logic              o_in_ready,
   output logic              o_im_we,
   output logic [ADDR_W-1:0] o_im_addr,
   output logic [31:0]       o_im_wdata,
   output logic              o_cpu_hold,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_err,
   output logic [ADDR_W:0]   o_word_count
);

   localparam int WC_W = ADDR_W + 1;

   loader_state_t r_state, w_next_state;

   logic              r_im_we;
   logic [31:0]       r_im_wdata;
   logic [ADDR_W-1:0] r_addr;
   logic [WC_W-1:0]   r_word_count;
   logic [WC_W-1:0]   r_n;
   logic              r_cpu_hold;
   logic              r_done;
   logic              r_err;

   logic        w_busy;
   logic        w_accept;
   logic        w_start_load;
   logic        w_last_word;
   logic        w_byte_en;
   logic [31:0] w_next_word;
   logic [7:0]  w_xor;
   logic        w_word_ready;

   assign w_busy       = (r_state == S_LEN) || (r_state == S_DATA) || (r_state == S_CHK);
   assign o_in_ready   = w_busy && !r_im_we;
   assign w_accept     = i_in_valid && o_in_ready;
   assign w_start_load = i_start &&
                         ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR));
   assign w_last_word  = (r_word_count + WC_W'(1)) == r_n;
   assign w_byte_en    = w_accept && (r_state == S_DATA);

   byte_word_packer u_packer (
      .clk          (clk),
      .rst          (rst),
      .i_clear      (w_start_load),
      .i_byte_en    (w_byte_en),
      .i_byte       (i_in_data),
      .o_next_word  (w_next_word),
      .o_xor        (w_xor),
      .o_word_ready (w_word_ready)
   );

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next_state;
   end

   always_comb begin
      // NOTE: default first so every path assigns w_next_state and no latch is inferred.
      w_next_state = r_state;
      case (r_state)
         S_IDLE, S_DONE, S_ERR: if (i_start) w_next_state = S_LEN;
         S_LEN:                 if (w_accept) w_next_state = S_DATA;
         // Leave DATA only once the final word's write cycle has completed.
         S_DATA:                if (r_im_we && w_last_word) w_next_state = S_CHK;
         S_CHK: begin
            if (w_accept) w_next_state = (i_in_data == w_xor) ? S_DONE : S_ERR;
         end
         default:               w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_im_we      <= 1'b0;
         r_im_wdata   <= '0;
         r_addr       <= '0;
         r_word_count <= '0;
         r_n          <= '0;
         r_cpu_hold   <= 1'b0;
         r_done       <= 1'b0;
         r_err        <= 1'b0;
      end else begin
         r_im_we <= w_word_ready;
         if (w_word_ready) r_im_wdata <= w_next_word;

         if (w_start_load) begin
            r_cpu_hold   <= 1'b1;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_word_count <= '0;
            r_addr       <= '0;
         end

         if ((r_state == S_LEN) && w_accept) r_n <= WC_W'(len_to_words(i_in_data));

         if (r_im_we) begin
            r_addr       <= r_addr + ADDR_W'(1);
            r_word_count <= r_word_count + WC_W'(1);
         end

         if ((r_state == S_CHK) && w_accept) begin
            if (i_in_data == w_xor) begin
               r_done     <= 1'b1;
               r_cpu_hold <= 1'b0;
            end else begin
               r_err      <= 1'b1;
            end
         end
      end
   end

   assign o_im_we      = r_im_we;
   assign o_im_addr    = r_addr;
   assign o_im_wdata   = r_im_wdata;
   assign o_cpu_hold   = r_cpu_hold;
   assign o_busy       = w_busy;
   assign o_done       = r_done;
   assign o_err        = r_err;
   assign o_word_count = r_word_count;

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the processor's word-addressed instruction memory. It accepts a framed byte stream over a valid/ready handshake, packs bytes big-endian into 32-bit instruction words, and writes them to consecutive instruction-memory addresses starting at 0. It holds the processor in reset (`cpu_hold`) for the whole load and releases it only after the frame's checksum verifies. It sits between the host-side byte source and the instruction memory's write port, feeding the PC/IM fetch path.

## Interface
- `ADDR_W`, default 8: instruction-memory word-address width; 256 words, matching the PC's +1 word addressing.
- `clk` input, 1 bit: clock; all state updates on the rising edge.
- `rst` input, 1 bit: reset, synchronous, active-high.
- `start` input, 1 bit: one-cycle request to begin a load; sampled only in IDLE, DONE or ERR.
- `in_valid` input, 1 bit: byte source has `in_data` valid.
- `in_data` input, 8 bits: stream byte.
- `in_ready` output, 1 bit: loader accepts a byte this cycle.
- `im_we` output, 1 bit: instruction-memory write strobe, one cycle per word.
- `im_addr` output, `ADDR_W` bits: word address for the write.
- `im_wdata` output, 32 bits: instruction word for the write.
- `cpu_hold` output, 1 bit: drive into the processor reset; high while loading or after an error.
- `busy` output, 1 bit: high in LEN, DATA and CHK.
- `done` output, 1 bit: sticky; load completed with a good checksum.
- `err` output, 1 bit: sticky; checksum mismatch.
- `word_count` output, `ADDR_W`+1 bits: number of words written in the current or last load.

## Operation
- Frame layout: LEN byte N (0 encodes 256), then 4·N data bytes, then one CHK byte.
- CHK is the XOR of all 4·N data bytes. LEN is excluded.
- States: IDLE, LEN, DATA, CHK, DONE, ERR.
  - IDLE --start--> LEN. On this transition, clear `done`, `err`, `word_count`, the address counter, the byte index and the XOR accumulator, and set `cpu_hold`.
  - LEN --byte--> DATA. Latch N.
  - DATA: each accepted byte shifts into the word register with the first byte at [31:24] and is XORed into the accumulator. The 4th byte of a word fires a write. After the write for word N, go to CHK.
  - CHK --byte--> DONE if the byte equals the accumulator, otherwise ERR.
  - DONE: `done`=1, `cpu_hold`=0. `start` re-enters LEN.
  - ERR: `err`=1, `cpu_hold` stays 1. `start` re-enters LEN.
- A byte is accepted when `in_valid` & `in_ready` are both high at a rising edge. `in_ready` = 1 in LEN, DATA and CHK, with one exception: it is 0 in the cycle `im_we` is high.
- `start` in LEN, DATA or CHK is ignored.
- Words already written before an error are not rolled back.
- `im_addr` wraps naturally. It never exceeds 255 for `ADDR_W`=8, because N ≤ 256.
- Reset values: `in_ready`=0, `im_we`=0, `im_addr`=0, `im_wdata`=0, `cpu_hold`=0, `busy`=0, `done`=0, `err`=0, `word_count`=0; state=IDLE.
- `rst` mid-load aborts immediately to the reset values. The partial instruction-memory contents are left as written.

## Timing
- `im_we`, `im_addr` and `im_wdata` are registered. `im_we` is high for exactly the one cycle after the edge that accepted byte 4 of a word.
- `im_addr` = word index, 0 for the first word. It and `word_count` increment on the edge ending the `im_we` cycle.
- Back-to-back input therefore takes 5 cycles per word: 4 accepts plus the write bubble.
- `cpu_hold` rises on the edge that samples `start` and falls on the edge that enters DONE.
- `busy` falls on that same edge.
- `done` and `err` go high on the edge accepting the CHK byte.
- Minimum load time: 1 (start) + 1 (LEN) + 5·N + 1 (CHK) cycles.

## Structure
- Shared package holds:
  - the state encoding (3-bit localparams);
  - `LOADER_BYTES_PER_WORD`=4;
  - the constant for LEN=0 meaning 256.
- One sub-module is natural: `byte_word_packer`. It contains the shift register, the 2-bit byte index and the XOR accumulator, and outputs `word_ready`.

## Test plan
- N=1, bytes 0x20,0x08,0x00,0x05, CHK 0x2D -> one `im_we` at addr 0 with data 0x20080005. `done`=1, `cpu_hold` drops, `word_count`=1.
- N=2, words 0x00221820 and 0x08000000, CHK = XOR of all 8 bytes -> writes at addr 0 and addr 1. `in_ready`=0 in each `im_we` cycle.
- N=1, correct data, CHK 0x00 -> `err`=1, `done`=0, `cpu_hold` stays 1. A following `start` clears `err` and reloads.
- N=0 (256 words) with random data and `in_valid` toggled every other cycle -> 256 writes at addr 0..255, `word_count`=256, `done`=1.
- Assert `rst` after 2 bytes of word 3 -> all outputs at reset values next cycle. A new `start` writes again from addr 0.
- `start` pulsed while in DATA -> ignored; frame completes normally and the write count is unchanged.
